// File: rtl/bcd_pkg.sv
// Shared constants for the iterative double-dabble converter:
// FSM state encoding and digit adjust thresholds.
package bcd_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int BCD_W = 4;

   localparam logic [3:0] ADJ_THRESH = 4'd4;
   localparam logic [3:0] ADJ_ADD    = 4'd3;
endpackage

// File: rtl/bcd_convert_sequencer_if.sv
// Producer/consumer handshake bundle for the BCD converter.
// master = producer+consumer side, slave = converter.
interface bcd_convert_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_bcd;
   logic                  overflow;
   logic                  busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_bcd, overflow, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_bcd, overflow, busy
   );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit above 4
// so the following left shift carries correctly into the next digit.
import bcd_pkg::*;

module bcd_digit_adjust (
   input  logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] adjusted
);
   assign adjusted = (digit > ADJ_THRESH) ? digit + ADJ_ADD : digit;
endmodule

// File: rtl/bcd_convert_sequencer.sv
// Bit-serial binary-to-BCD converter: one shift-and-add-3 step per
// clock, valid/ready on both sides, sticky overflow for the top digit.
import bcd_pkg::*;

module bcd_convert_sequencer #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
) (
   input  logic clk,
   input  logic rst,
   bcd_convert_sequencer_if.slave bus
);
   localparam int ACC_W = BCD_W * DIGITS;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [1:0]        state;
   logic [DATA_W-1:0] sreg;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  adj;
   logic [CNT_W-1:0]  count;
   logic              ovf;
   logic              last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (acc[g*BCD_W +: BCD_W]),
         .adjusted (adj[g*BCD_W +: BCD_W])
      );
   end

   assign last = (count == CNT_W'(DATA_W - 1));

   // A set MSB of the adjusted top digit is a carry lost by the shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         sreg  <= '0;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sreg  <= bus.in_data;
                  acc   <= '0;
                  count <= '0;
                  ovf   <= 1'b0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               acc   <= {adj[ACC_W-2:0], sreg[DATA_W-1]};
               sreg  <= sreg << 1;
               count <= count + CNT_W'(1);
               if (adj[ACC_W-1]) ovf <= 1'b1;
               if (last) state <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out_bcd   = acc;
   assign bus.overflow  = ovf;
endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Directed bench for bcd_convert_sequencer: default 8/3 instance plus
// 10/3 overflow and 1/1 minimum-width instances.
module tb_bcd_convert_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rdy_bad = 0;

   always #5 clk = ~clk;

   bcd_convert_sequencer_if #(.DATA_W(8),  .DIGITS(3)) a ();
   bcd_convert_sequencer_if #(.DATA_W(10), .DIGITS(3)) b ();
   bcd_convert_sequencer_if #(.DATA_W(1),  .DIGITS(1)) c ();

   bcd_convert_sequencer #(.DATA_W(8),  .DIGITS(3)) u_a (.clk(clk), .rst(rst), .bus(a));
   bcd_convert_sequencer #(.DATA_W(10), .DIGITS(3)) u_b (.clk(clk), .rst(rst), .bus(b));
   bcd_convert_sequencer #(.DATA_W(1),  .DIGITS(1)) u_c (.clk(clk), .rst(rst), .bus(c));

   typedef struct {
      logic [7:0]  data;
      logic [11:0] bcd;
      logic        ovf;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] dec3(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Each run: present d, wait for accept, count edges until out_valid,
   // then count busy cycles until the result is consumed (out_ready=1).
   task automatic run_a(input logic [7:0] d, output int lat,
                        output int bsy, output logic [11:0] bcd,
                        output logic ovf);
      int t;
      @(negedge clk);
      a.in_valid = 1'b1;
      a.in_data  = d;
      t = 0;
      while (!a.in_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      a.in_valid = 1'b0;
      lat = 0;
      bsy = 0;
      while (!a.out_valid && lat < 100) begin
         if (a.busy) bsy++;
         if (a.in_ready) rdy_bad++;
         @(negedge clk);
         lat++;
      end
      bcd = a.out_bcd;
      ovf = a.overflow;
      t = 0;
      while (a.busy && t < 100) begin
         bsy++;
         if (a.in_ready) rdy_bad++;
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_b(input logic [9:0] d, output int lat,
                        output logic [11:0] bcd, output logic ovf);
      int t;
      @(negedge clk);
      b.in_valid = 1'b1;
      b.in_data  = d;
      t = 0;
      while (!b.in_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      b.in_valid = 1'b0;
      lat = 0;
      while (!b.out_valid && lat < 100) begin @(negedge clk); lat++; end
      bcd = b.out_bcd;
      ovf = b.overflow;
      @(negedge clk);
   endtask

   task automatic run_c(input logic d, output int lat,
                        output logic [3:0] bcd, output logic ovf);
      int t;
      @(negedge clk);
      c.in_valid = 1'b1;
      c.in_data  = d;
      t = 0;
      while (!c.in_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      c.in_valid = 1'b0;
      lat = 0;
      while (!c.out_valid && lat < 100) begin @(negedge clk); lat++; end
      bcd = c.out_bcd;
      ovf = c.overflow;
      @(negedge clk);
   endtask

   initial begin
      vec_t        vt[10];
      int          lat, bsy, t;
      logic [11:0] bcd;
      logic [3:0]  bcd1;
      logic        ovf;

      vt[0] = '{8'd0,   12'h000, 1'b0};
      vt[1] = '{8'd1,   12'h001, 1'b0};
      vt[2] = '{8'd9,   12'h009, 1'b0};
      vt[3] = '{8'd10,  12'h010, 1'b0};
      vt[4] = '{8'd42,  12'h042, 1'b0};
      vt[5] = '{8'd99,  12'h099, 1'b0};
      vt[6] = '{8'd100, 12'h100, 1'b0};
      vt[7] = '{8'd128, 12'h128, 1'b0};
      vt[8] = '{8'd200, 12'h200, 1'b0};
      vt[9] = '{8'd255, 12'h255, 1'b0};

      a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
      b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
      c.in_valid = 1'b0; c.in_data = '0; c.out_ready = 1'b1;

      #12;
      chk("rst_in_ready",  a.in_ready,  1);
      chk("rst_out_valid", a.out_valid, 0);
      chk("rst_busy",      a.busy,      0);
      chk("rst_out_bcd",   a.out_bcd,   0);
      chk("rst_overflow",  a.overflow,  0);
      chk("rst_b_ready",   b.in_ready,  1);
      chk("rst_c_ready",   c.in_ready,  1);
      @(negedge clk);
      rst = 1'b0;

      run_a(8'd255, lat, bsy, bcd, ovf);
      chk("lat_255",  lat, 8);
      chk("busy_255", bsy, 9);
      chk("bcd_255",  bcd, 12'h255);
      chk("ovf_255",  ovf, 0);

      for (int i = 0; i < 10; i++) begin
         run_a(vt[i].data, lat, bsy, bcd, ovf);
         chk($sformatf("vec_bcd_%0d", vt[i].data), bcd, vt[i].bcd);
         chk($sformatf("vec_ovf_%0d", vt[i].data), ovf, vt[i].ovf);
         chk($sformatf("vec_lat_%0d", vt[i].data), lat, 8);
      end

      for (int v = 0; v < 256; v++) begin
         run_a(8'(v), lat, bsy, bcd, ovf);
         chk($sformatf("sweep_bcd_%0d", v), bcd, dec3(v));
         chk($sformatf("sweep_ovf_%0d", v), ovf, 0);
      end
      chk("in_ready_while_busy", rdy_bad, 0);

      // Backpressure: hold DONE for 20 cycles with a new word waiting
      @(negedge clk);
      a.out_ready = 1'b0;
      a.in_valid  = 1'b1;
      a.in_data   = 8'd123;
      @(negedge clk);
      a.in_data = 8'd7;
      t = 0;
      while (!a.out_valid && t < 100) begin @(negedge clk); t++; end
      for (int i = 0; i < 20; i++) begin
         chk("bp_valid", a.out_valid, 1);
         chk("bp_bcd",   a.out_bcd,   12'h123);
         chk("bp_ready", a.in_ready,  0);
         @(negedge clk);
      end
      a.out_ready = 1'b1;
      chk("bp_ready_on_take", a.in_ready, 0);
      @(negedge clk);
      chk("bp_idle_ready", a.in_ready, 1);
      @(negedge clk);
      a.in_valid = 1'b0;
      t = 0;
      while (!a.out_valid && t < 100) begin @(negedge clk); t++; end
      chk("bp_next_bcd", a.out_bcd, 12'h007);
      @(negedge clk);

      // Reset three cycles into a conversion of 200
      a.in_valid = 1'b1;
      a.in_data  = 8'd200;
      @(negedge clk);
      a.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", a.busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", a.out_valid, 0);
      chk("mid_rst_busy",  a.busy,      0);
      chk("mid_rst_ready", a.in_ready,  1);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_no_valid", a.out_valid, 0);
      run_a(8'd42, lat, bsy, bcd, ovf);
      chk("post_rst_bcd", bcd, 12'h042);
      chk("post_rst_lat", lat, 8);

      run_b(10'd1023, lat, bcd, ovf);
      chk("w10_1023_bcd", bcd, 12'h023);
      chk("w10_1023_ovf", ovf, 1);
      chk("w10_1023_lat", lat, 10);
      run_b(10'd999, lat, bcd, ovf);
      chk("w10_999_bcd", bcd, 12'h999);
      chk("w10_999_ovf", ovf, 0);
      run_b(10'd1000, lat, bcd, ovf);
      chk("w10_1000_bcd", bcd, 12'h000);
      chk("w10_1000_ovf", ovf, 1);

      run_c(1'b1, lat, bcd1, ovf);
      chk("w1_one_bcd", bcd1, 4'h1);
      chk("w1_one_lat", lat, 1);
      chk("w1_one_ovf", ovf, 0);
      run_c(1'b0, lat, bcd1, ovf);
      chk("w1_zero_bcd", bcd1, 4'h0);
      chk("w1_zero_lat", lat, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
